biriscv_mul_pipe: RTL

BIRISCV_MUL_PIPE -- requirements
Module: biriscv_mul_pipe

---
 rtl/biriscv_mul_pipe_if.sv | 32 +++
 rtl/biriscv_mul_pipe.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/biriscv_mul_pipe_if.sv
// Issue, control and writeback bundle for the pipelined RV32M multiplier.
// Signal names match the original flat port list for drop-in compatibility.
interface biriscv_mul_pipe_if #(
  parameter int unsigned REG_IDX_W = 5
);
  logic                      opcode_valid_i;
  logic [31:0]               opcode_opcode_i;
  logic [REG_IDX_W-1:0]      opcode_rd_idx_i;
  logic [31:0]               opcode_ra_operand_i;
  logic [31:0]               opcode_rb_operand_i;
  logic                      hold_i;
  logic                      flush_i;
  logic                      writeback_valid_o;
  logic [REG_IDX_W-1:0]      writeback_rd_idx_o;
  logic [31:0]               writeback_value_o;
  logic                      busy_o;
  logic [2**REG_IDX_W-1:0]   pending_rd_o;

  modport master (
    output opcode_valid_i, opcode_opcode_i, opcode_rd_idx_i,
           opcode_ra_operand_i, opcode_rb_operand_i, hold_i, flush_i,
    input  writeback_valid_o, writeback_rd_idx_o, writeback_value_o,
           busy_o, pending_rd_o
  );

  modport slave (
    input  opcode_valid_i, opcode_opcode_i, opcode_rd_idx_i,
           opcode_ra_operand_i, opcode_rb_operand_i, hold_i, flush_i,
    output writeback_valid_o, writeback_rd_idx_o, writeback_value_o,
           busy_o, pending_rd_o
  );
endinterface

// File: rtl/biriscv_mul_pipe.sv
// Pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) with MULT_STAGES-cycle
// latency, stall, flush and a one-hot pending-rd vector for hazard checks.
module biriscv_mul_pipe #(
  parameter int unsigned MULT_STAGES = 2,
  parameter int unsigned REG_IDX_W   = 5
) (
  input logic               clk,
  input logic               rst_n,
  biriscv_mul_pipe_if.slave mul_if
);

  localparam logic [31:0] MUL_MASK    = 32'hfe00707f;
  localparam logic [31:0] INST_MUL    = 32'h02000033;
  localparam logic [31:0] INST_MULH   = 32'h02001033;
  localparam logic [31:0] INST_MULHSU = 32'h02002033;
  localparam logic [31:0] INST_MULHU  = 32'h02003033;

  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} mul_op_e;

  mul_op_e               op_sel;
  logic                  op_match;
  logic                  accept;
  logic [32:0]           a_ext;
  logic [32:0]           b_ext;
  logic                  hi_sel;

  logic                  s1_valid;
  logic [REG_IDX_W-1:0]  s1_rd;
  logic [32:0]           s1_a;
  logic [32:0]           s1_b;
  logic                  s1_hi;

  logic signed [63:0]    a_wide;
  logic signed [63:0]    b_wide;
  logic signed [63:0]    prod;
  logic [31:0]           result_d;

  logic                  stg_valid [2:MULT_STAGES];
  logic [REG_IDX_W-1:0]  stg_rd    [2:MULT_STAGES];
  logic [31:0]           stg_res   [2:MULT_STAGES];

  logic                    busy;
  logic [2**REG_IDX_W-1:0] pending;

  always_comb begin
    op_match = 1'b0;
    op_sel   = OP_MUL;
    case (mul_if.opcode_opcode_i & MUL_MASK)
      INST_MUL:    begin op_match = 1'b1; op_sel = OP_MUL;    end
      INST_MULH:   begin op_match = 1'b1; op_sel = OP_MULH;   end
      INST_MULHSU: begin op_match = 1'b1; op_sel = OP_MULHSU; end
      INST_MULHU:  begin op_match = 1'b1; op_sel = OP_MULHU;  end
      default:     ;
    endcase
  end

  assign accept = mul_if.opcode_valid_i & op_match & ~mul_if.hold_i & ~mul_if.flush_i;

  // Non-accepted cycles feed zero operands so a bubble carries no stale data.
  always_comb begin
    a_ext  = '0;
    b_ext  = '0;
    hi_sel = 1'b0;
    if (accept) begin
      case (op_sel)
        OP_MULH: begin
          a_ext  = {mul_if.opcode_ra_operand_i[31], mul_if.opcode_ra_operand_i};
          b_ext  = {mul_if.opcode_rb_operand_i[31], mul_if.opcode_rb_operand_i};
          hi_sel = 1'b1;
        end
        OP_MULHSU: begin
          a_ext  = {mul_if.opcode_ra_operand_i[31], mul_if.opcode_ra_operand_i};
          b_ext  = {1'b0, mul_if.opcode_rb_operand_i};
          hi_sel = 1'b1;
        end
        OP_MULHU: begin
          a_ext  = {1'b0, mul_if.opcode_ra_operand_i};
          b_ext  = {1'b0, mul_if.opcode_rb_operand_i};
          hi_sel = 1'b1;
        end
        default: begin
          a_ext  = {1'b0, mul_if.opcode_ra_operand_i};
          b_ext  = {1'b0, mul_if.opcode_rb_operand_i};
          hi_sel = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_rd    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_hi    <= 1'b0;
    end else begin
      if (!mul_if.hold_i) begin
        s1_a  <= a_ext;
        s1_b  <= b_ext;
        s1_hi <= hi_sel;
        s1_rd <= accept ? mul_if.opcode_rd_idx_i : '0;
      end
      if (mul_if.flush_i)
        s1_valid <= 1'b0;
      else if (!mul_if.hold_i)
        s1_valid <= accept;
    end
  end

  // Only the low 64 bits of the 66-bit signed product are ever selected,
  // so the product is formed directly at 64 bits from sign-extended operands.
  assign a_wide   = {{31{s1_a[32]}}, s1_a};
  assign b_wide   = {{31{s1_b[32]}}, s1_b};
  assign prod     = a_wide * b_wide;
  assign result_d = s1_hi ? prod[63:32] : prod[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 2; i <= MULT_STAGES; i++) begin
        stg_valid[i] <= 1'b0;
        stg_rd[i]    <= '0;
        stg_res[i]   <= '0;
      end
    end else begin
      if (!mul_if.hold_i) begin
        stg_rd[2]  <= s1_rd;
        stg_res[2] <= result_d;
        for (int unsigned i = 3; i <= MULT_STAGES; i++) begin
          stg_rd[i]  <= stg_rd[i-1];
          stg_res[i] <= stg_res[i-1];
        end
      end
      if (mul_if.flush_i) begin
        for (int unsigned i = 2; i <= MULT_STAGES; i++)
          stg_valid[i] <= 1'b0;
      end else if (!mul_if.hold_i) begin
        stg_valid[2] <= s1_valid;
        for (int unsigned i = 3; i <= MULT_STAGES; i++)
          stg_valid[i] <= stg_valid[i-1];
      end
    end
  end

  always_comb begin
    busy    = s1_valid;
    pending = '0;
    if (s1_valid)
      pending[s1_rd] = 1'b1;
    for (int unsigned i = 2; i <= MULT_STAGES; i++) begin
      busy = busy | stg_valid[i];
      if (stg_valid[i])
        pending[stg_rd[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign mul_if.writeback_valid_o  = stg_valid[MULT_STAGES];
  assign mul_if.writeback_rd_idx_o = stg_rd[MULT_STAGES];
  assign mul_if.writeback_value_o  = stg_valid[MULT_STAGES] ? stg_res[MULT_STAGES] : '0;
  assign mul_if.busy_o             = busy;
  assign mul_if.pending_rd_o       = pending;

endmodule
